lpc_host: RTL and testbench

- LPC initiator: turns one queued request into a complete LPC I/O or memory read/write cycle on the bus. It is the transmit-side counterpart of the sniffer's LPC decoder.
- Drives START, CYCTYPE/DIR, address, write data and TAR, then samples SYNC and read data from the peripheral.
- Used as a bench bus driver for the sniffer and as a standalone host for probing target ports (e.g. POST port 0x80).
- Runs entirely in the LPC clock domain.

---
 rtl/lpc_host.sv | 161 ++++++++++++++++
 tb/tb_lpc_host.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host.sv
// LPC initiator: runs one queued request as a complete LPC I/O or memory cycle
// on LFRAME#/LAD[3:0], then returns SYNC status and read data as a one-cycle response.
module lpc_host #(
    parameter int SYNC_TIMEOUT = 32,
    parameter int TW           = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCT, S_ADDR, S_WDATA, S_TAR1, S_TAR2, S_SYNC,
        S_RDATA, S_PTAR1, S_PTAR2, S_ABORT, S_ABORT_END, S_DONE
    } state_t;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    state_t         state, state_next;
    logic [3:0]     cyc_q;
    logic [31:0]    addr_sh;
    logic [7:0]     data_sh;
    logic [7:0]     rdata;
    logic [TW-1:0]  cnt;
    logic           ready_q;
    logic           accept;
    logic           is_mem;
    logic           is_write;
    logic           sync_done;

    assign accept    = (state == S_IDLE) && req_valid && ready_q;
    assign is_mem    = cyc_q[2];
    assign is_write  = cyc_q[1];
    assign sync_done = (lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERROR);
    assign req_ready = ready_q;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_next = state;
        lpc_frame  = 1'b1;
        lpc_ad_oe  = 1'b0;
        lpc_ad_out = 4'b0000;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_next = req_cyctype_dir[3] ? S_DONE : S_START;
            end
            S_START: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                state_next = S_CYCT;
            end
            S_CYCT: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = cyc_q;
                state_next = S_ADDR;
            end
            S_ADDR: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = addr_sh[31:28];
                if (cnt == (is_mem ? TW'(7) : TW'(3)))
                    state_next = is_write ? S_WDATA : S_TAR1;
            end
            S_WDATA: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = data_sh[3:0];
                if (cnt == TW'(1))
                    state_next = S_TAR1;
            end
            S_TAR1: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = 4'b1111;
                state_next = S_TAR2;
            end
            S_TAR2: state_next = S_SYNC;
            S_SYNC: begin
                if (sync_done)
                    state_next = is_write ? S_PTAR1 : S_RDATA;
                else if (cnt == TW'(SYNC_TIMEOUT - 1))
                    state_next = S_ABORT;
            end
            S_RDATA: begin
                if (cnt == TW'(1))
                    state_next = S_PTAR1;
            end
            S_PTAR1: state_next = S_PTAR2;
            S_PTAR2: state_next = S_DONE;
            S_ABORT: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = 4'b1111;
                if (cnt == TW'(3))
                    state_next = S_ABORT_END;
            end
            S_ABORT_END: state_next = S_DONE;
            S_DONE: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 4'b0000;
            addr_sh     <= 32'h0;
            data_sh     <= 8'h00;
            rdata       <= 8'h00;
            cnt         <= '0;
            rsp_data    <= 8'h00;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == S_IDLE);
            // One shared phase counter: restarts whenever the state changes.
            cnt     <= (state_next != state) ? '0 : cnt + TW'(1);

            if (accept) begin
                cyc_q       <= req_cyctype_dir & 4'b1110;
                addr_sh     <= req_cyctype_dir[2] ? req_addr : {req_addr[15:0], 16'h0000};
                data_sh     <= req_data;
                rsp_error   <= req_cyctype_dir[3];
                rsp_timeout <= 1'b0;
            end

            case (state)
                S_ADDR:      addr_sh <= addr_sh << 4;
                S_WDATA:     data_sh <= data_sh >> 4;
                S_SYNC:      if (lpc_ad_in == SYNC_ERROR) rsp_error <= 1'b1;
                S_RDATA:     rdata <= {lpc_ad_in, rdata[7:4]};
                S_ABORT_END: rsp_timeout <= 1'b1;
                default: ;
            endcase

            if (state == S_PTAR2)
                rsp_data <= is_write ? 8'h00 : rdata;
            else if (state_next == S_DONE)
                rsp_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a table of complete LPC cycles against a scripted
// peripheral, plus hand-written timeout, back-to-back and mid-cycle reset sequences.
module tb_lpc_host;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [7:0]  req_data = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;

    int total = 0;
    int bad   = 0;

    lpc_host #(.SYNC_TIMEOUT(32), .TW(6)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .lpc_frame(lpc_frame), .lpc_ad_out(lpc_ad_out),
        .lpc_ad_oe(lpc_ad_oe), .lpc_ad_in(lpc_ad_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  cyc;
        logic [31:0] addr;
        logic [7:0]  data;
        int          sync_k;     // cycle index (START=0) of the first SYNC cycle
        int          waits;      // SYNC cycles answered with wait_val before ready_val
        logic [3:0]  wait_val;
        logic [3:0]  ready_val;
        logic [7:0]  rd;         // read data returned by the peripheral
        int          exp_done;   // cycle index of rsp_valid
        logic [63:0] exp_nibs;   // LAD nibbles driven by the host, first at [63:60]
        int          exp_n;
        logic        chk_data;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, " ready_wait"}, {63'h0, req_ready}, 64'h1);
    endtask

    function automatic logic [3:0] periph(input vec_t v, input int k);
        int s = v.sync_k + v.waits;
        if (k >= v.sync_k && k < s) return v.wait_val;
        if (k == s)                 return v.ready_val;
        if (k == s + 1)             return v.rd[3:0];
        if (k == s + 2)             return v.rd[7:4];
        return 4'hF;
    endfunction

    task automatic issue(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] data);
        req_valid       = 1'b1;
        req_cyctype_dir = cyc;
        req_addr        = addr;
        req_data        = data;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] nibs = 64'h0;
        int n = 0, done_k = -1, frame_low = 0, ready_hi = 0;
        logic frame_at0 = 1'b0;
        logic [7:0] got_data = 8'h00;
        logic got_err = 1'b0, got_tmo = 1'b1;
        wait_ready(tag);
        issue(v.cyc, v.addr, v.data);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (k == 0) begin
                // Scramble the request after acceptance: only the latched copy may matter.
                req_valid = 1'b0;
                req_addr = $urandom;
                req_data = 8'($urandom);
                req_cyctype_dir = 4'b0110;
            end
            lpc_ad_in = periph(v, k);
            if (rsp_valid) begin
                done_k = k;
                got_data = rsp_data;
                got_err = rsp_error;
                got_tmo = rsp_timeout;
                break;
            end
            if (req_ready) ready_hi++;
            if (!lpc_frame) begin
                frame_low++;
                if (k == 0) frame_at0 = 1'b1;
            end
            if (lpc_ad_oe) begin
                if (n < 16) nibs[63 - 4*n -: 4] = lpc_ad_out;
                n++;
            end
        end
        check({tag, " done_cycle"}, 64'(done_k), 64'(v.exp_done));
        if (v.chk_data) check({tag, " rsp_data"}, {56'h0, got_data}, {56'h0, v.exp_data});
        check({tag, " rsp_error"}, {63'h0, got_err}, {63'h0, v.exp_err});
        check({tag, " rsp_timeout"}, {63'h0, got_tmo}, 64'h0);
        check({tag, " nibbles"}, nibs, v.exp_nibs);
        check({tag, " nibble_count"}, 64'(n), 64'(v.exp_n));
        check({tag, " frame_low_cycles"}, 64'(frame_low), (v.exp_n == 0) ? 64'h0 : 64'h1);
        check({tag, " frame_low_at_start"}, {63'h0, frame_at0}, (v.exp_n == 0) ? 64'h0 : 64'h1);
        check({tag, " ready_low_in_cycle"}, 64'(ready_hi), 64'h0);
        @(negedge clock);
        check({tag, " rsp_pulse_one"}, {63'h0, rsp_valid}, 64'h0);
        check({tag, " ready_after"}, {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        //          cyc     addr           data   sk w  wait   ready  rd     done nibbles                n  chk data   err
        vecs[0] = '{4'b0010, 32'h0000_0080, 8'h34, 10, 0, 4'h5, 4'h0, 8'h00, 13, 64'h0200_8043_F000_0000, 9, 1, 8'h00, 0};
        vecs[1] = '{4'b0000, 32'h0000_03F9, 8'h00,  8, 2, 4'h5, 4'h0, 8'hA5, 15, 64'h0003_F9F0_0000_0000, 7, 1, 8'hA5, 0};
        vecs[2] = '{4'b0100, 32'hFFFF_FFF0, 8'h00, 12, 0, 4'h5, 4'hA, 8'hEE, 17, 64'h04FF_FFFF_F0F0_0000, 11, 1, 8'hEE, 1};
        vecs[3] = '{4'b0010, 32'h0000_ABCD, 8'h7E, 10, 2, 4'h3, 4'hA, 8'h00, 15, 64'h02AB_CDE7_F000_0000, 9, 1, 8'h00, 1};
        vecs[4] = '{4'b1000, 32'h0000_0080, 8'h11,  0, 0, 4'h5, 4'h0, 8'h00,  0, 64'h0, 0, 0, 8'h00, 1};
        vecs[5] = '{4'b1110, 32'h1234_5678, 8'h22,  0, 0, 4'h5, 4'h0, 8'h00,  0, 64'h0, 0, 0, 8'h00, 1};
        vecs[6] = '{4'b0001, 32'h0000_0080, 8'h00,  8, 1, 4'h6, 4'h0, 8'h3C, 14, 64'h0000_80F0_0000_0000, 7, 1, 8'h3C, 0};

        // Reset state
        #12;
        check("reset frame", {63'h0, lpc_frame}, 64'h1);
        check("reset oe", {63'h0, lpc_ad_oe}, 64'h0);
        check("reset ad_out", {60'h0, lpc_ad_out}, 64'h0);
        check("reset ready", {63'h0, req_ready}, 64'h0);
        check("reset rsp", {53'h0, rsp_valid, rsp_data, rsp_error, rsp_timeout}, 64'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ready after reset", {63'h0, req_ready}, 64'h1);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // SYNC held at long-wait: 32 SYNC cycles (k=8..39), abort k=40..43, release k=44, done k=45
        begin
            int done_k = -1;
            int abort_ok = 0;
            wait_ready("tmo");
            issue(4'b0000, 32'h0000_0080, 8'h00);
            lpc_ad_in = 4'b0110;
            for (int k = 0; k < 60; k++) begin
                @(negedge clock);
                if (k == 0) req_valid = 1'b0;
                if (k >= 40 && k <= 43 && !lpc_frame && lpc_ad_oe && lpc_ad_out == 4'hF) abort_ok++;
                if (k == 39) check("tmo still sync", {62'h0, lpc_frame, lpc_ad_oe}, 64'h2);
                if (k == 44) check("tmo release", {62'h0, lpc_frame, lpc_ad_oe}, 64'h2);
                if (rsp_valid) begin
                    done_k = k;
                    check("tmo rsp_timeout", {63'h0, rsp_timeout}, 64'h1);
                    check("tmo rsp_data", {56'h0, rsp_data}, 64'h0);
                    break;
                end
            end
            check("tmo abort cycles", 64'(abort_ok), 64'd4);
            check("tmo done cycle", 64'(done_k), 64'd45);
            @(negedge clock);
            check("tmo ready after", {63'h0, req_ready}, 64'h1);
            lpc_ad_in = 4'hF;
        end

        // Back-to-back with req_valid held: write A, reserved B, write C
        begin
            wait_ready("b2b");
            lpc_ad_in = 4'b0000;
            issue(4'b0010, 32'h0000_0080, 8'h34);
            for (int k = 0; k < 32; k++) begin
                logic exp_rsp, exp_frame, exp_ready;
                @(negedge clock);
                exp_rsp   = (k == 13) || (k == 15) || (k == 30);
                exp_frame = !((k == 0) || (k == 17));
                exp_ready = (k == 14) || (k == 16) || (k == 31);
                check($sformatf("b2b rsp_valid k%0d", k), {63'h0, rsp_valid}, {63'h0, exp_rsp});
                check($sformatf("b2b frame k%0d", k), {63'h0, lpc_frame}, {63'h0, exp_frame});
                check($sformatf("b2b ready k%0d", k), {63'h0, req_ready}, {63'h0, exp_ready});
                if (k == 13) check("b2b A error", {63'h0, rsp_error}, 64'h0);
                if (k == 15) check("b2b B error", {63'h0, rsp_error}, 64'h1);
                if (k == 30) check("b2b C error", {63'h0, rsp_error}, 64'h0);
                if (k == 0)  issue(4'b1000, 32'h0000_0080, 8'h00);
                if (k == 15) issue(4'b0010, 32'h0000_0080, 8'h34);
                if (k == 17) req_valid = 1'b0;
            end
            lpc_ad_in = 4'hF;
        end

        // Reset asserted during ADDR: outputs idle immediately, no response
        begin
            int rsp_seen = 0;
            wait_ready("rst");
            issue(4'b0010, 32'h0000_0080, 8'h34);
            @(negedge clock);
            req_valid = 1'b0;
            repeat (3) @(negedge clock);
            check("rst in addr oe", {63'h0, lpc_ad_oe}, 64'h1);
            #2 reset = 1'b0;
            #1;
            check("rst frame", {63'h0, lpc_frame}, 64'h1);
            check("rst oe", {63'h0, lpc_ad_oe}, 64'h0);
            check("rst ready", {63'h0, req_ready}, 64'h0);
            repeat (3) begin
                @(negedge clock);
                if (rsp_valid) rsp_seen++;
            end
            check("rst no rsp", 64'(rsp_seen), 64'h0);
            reset = 1'b1;
            run_vec(vecs[0], "post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
